// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state, opcode and datapath select encodings for the multi-cycle core
package ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    TRAP     = 4'd10
  } state_t;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  function automatic state_t decode_next(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE: return MEMADR;
      OP_RTYPE:          return EXECR;
      OP_ITYPE:          return EXECI;
      OP_BRANCH:         return BEQ;
`ifdef ILLEGAL_TRAP_EN
      default:           return TRAP;
`else
      default:           return FETCH;
`endif
    endcase
  endfunction
endpackage

// File: rtl/retire_counter.sv
// retire_counter: wrapping retired-instruction counter with sync reset and increment enable
module retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else if (en) count <= count + CNT_W'(1);
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multi-cycle sequencing FSM; define ILLEGAL_TRAP_EN to trap unsupported opcodes
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             illegal
);
  state_t cur;
  logic   is_mem, retire;
  always_ff @(posedge clk)
    if (reset) cur <= FETCH;
    else case (cur)
      FETCH:    cur <= mem_ready ? DECODE : FETCH;
      DECODE:   cur <= decode_next(opcode);
      MEMADR:   cur <= opcode == OP_LOAD ? MEMREAD : MEMWRITE;
      MEMREAD:  cur <= mem_ready ? MEMWB : MEMREAD;
      MEMWRITE: cur <= mem_ready ? FETCH : MEMWRITE;
      EXECR:    cur <= ALUWB;
      EXECI:    cur <= ALUWB;
      TRAP:     cur <= TRAP;
      default:  cur <= FETCH;
    endcase
  // Strobes are gated by reset so an in-flight access is dropped immediately.
  assign is_mem     = cur == MEMREAD || cur == MEMWRITE;
  assign mem_req    = !reset && (cur == FETCH || is_mem);
  assign adr_src    = is_mem;
  assign mem_write  = !reset && cur == MEMWRITE;
  assign ir_write   = !reset && cur == FETCH && mem_ready;
  assign pc_write   = !reset && ((cur == FETCH && mem_ready) || (cur == BEQ && zero));
  assign reg_write  = !reset && (cur == MEMWB || cur == ALUWB);
  assign alu_src_a  = cur == DECODE ? SRCA_OLDPC :
                      (cur == MEMADR || cur == EXECR || cur == EXECI || cur == BEQ) ? SRCA_RS1 : SRCA_PC;
  assign alu_src_b  = cur == FETCH ? SRCB_FOUR :
                      (cur == DECODE || cur == MEMADR || cur == EXECI) ? SRCB_IMM : SRCB_RS2;
  assign alu_op     = (cur == EXECR || cur == EXECI) ? ALU_FUNCT : cur == BEQ ? ALU_SUB : ALU_ADD;
  assign result_src = cur == FETCH ? RES_ALU : cur == MEMWB ? RES_MEM : RES_ALUOUT;
  assign state      = cur;
  assign retire     = cur == MEMWB || cur == ALUWB || cur == BEQ || (cur == MEMWRITE && mem_ready);
`ifdef ILLEGAL_TRAP_EN
  assign illegal = cur == TRAP;
`else
  assign illegal = 1'b0;
`endif
  retire_counter #(.CNT_W(CNT_W)) u_retire (
    .clk  (clk),
    .reset(reset),
    .en   (retire),
    .count(retired)
  );
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed self-checking bench for multicycle_controller
module tb_multicycle_controller;
  import ctrl_pkg::*;
  logic clk = 0, reset, zero, mem_ready;
  logic [6:0] opcode;
  logic mem_req, adr_src, mem_write, ir_write, pc_write, reg_write, illegal;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [3:0] state;
  logic [31:0] retired;
  logic mem_req4, adr_src4, mem_write4, ir_write4, pc_write4, reg_write4, illegal4;
  logic [1:0] alu_src_a4, alu_src_b4, alu_op4, result_src4;
  logic [3:0] state4, retired4;
  int checks = 0, errors = 0;
  logic [31:0] exp_ret;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .state(state), .retired(retired), .illegal(illegal)
  );

  multicycle_controller #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req4), .adr_src(adr_src4), .mem_write(mem_write4), .ir_write(ir_write4),
    .pc_write(pc_write4), .reg_write(reg_write4), .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4),
    .alu_op(alu_op4), .result_src(result_src4), .state(state4), .retired(retired4), .illegal(illegal4)
  );

  task automatic test_reset;
    reset = 1; mem_ready = 1; zero = 0; opcode = 7'h00;
    @(negedge clk); #1;
    checks++; if (state !== 4'(FETCH)) begin errors++; $display("FAIL reset_state got %0d want %0d", state, FETCH); end
    checks++; if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired got %0d want 0", retired); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", illegal); end
    checks++; if ({mem_req, mem_write, ir_write, pc_write, reg_write} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes got %b want 00000", {mem_req, mem_write, ir_write, pc_write, reg_write}); end
    reset = 0; mem_ready = 0; #1;
    checks++; if ({mem_req, adr_src, ir_write, alu_src_b, result_src} !== 7'b1001010) begin
      errors++; $display("FAIL fetch_wait got %b want 1001010", {mem_req, adr_src, ir_write, alu_src_b, result_src}); end
    exp_ret = 0;
    @(negedge clk);
  endtask

  task automatic test_lw;
    state_t se[6] = '{FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH};
    opcode = OP_LOAD; mem_ready = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (state !== 4'(se[i])) begin errors++; $display("FAIL lw_state[%0d] got %0d want %0d", i, state, se[i]); end
      if (i == 3) begin
        checks++; if ({mem_req, adr_src, mem_write} !== 3'b110) begin
          errors++; $display("FAIL lw_memread got %b want 110", {mem_req, adr_src, mem_write}); end
      end
      if (i == 4) begin
        checks++; if ({reg_write, result_src} !== 3'b101) begin
          errors++; $display("FAIL lw_wb got %b want 101", {reg_write, result_src}); end
        checks++; if (retired !== exp_ret) begin errors++; $display("FAIL lw_ret_before got %0d want %0d", retired, exp_ret); end
      end
      if (i == 5) begin
        exp_ret++;
        checks++; if (retired !== exp_ret) begin errors++; $display("FAIL lw_ret_after got %0d want %0d", retired, exp_ret); end
      end
      if (i < 5) @(negedge clk);
    end
  endtask

  task automatic test_sw;
    state_t se[8] = '{FETCH, DECODE, MEMADR, MEMWRITE, MEMWRITE, MEMWRITE, MEMWRITE, FETCH};
    opcode = OP_STORE;
    for (int i = 0; i < 8; i++) begin
      mem_ready = !(i >= 3 && i <= 5); #1;
      checks++; if (state !== 4'(se[i])) begin errors++; $display("FAIL sw_state[%0d] got %0d want %0d", i, state, se[i]); end
      if (i >= 3 && i <= 6) begin
        checks++; if ({mem_req, mem_write, adr_src, reg_write} !== 4'b1110) begin
          errors++; $display("FAIL sw_hold[%0d] got %b want 1110", i, {mem_req, mem_write, adr_src, reg_write}); end
        checks++; if (retired !== exp_ret) begin errors++; $display("FAIL sw_ret_wait[%0d] got %0d want %0d", i, retired, exp_ret); end
      end
      if (i == 7) begin
        exp_ret++;
        checks++; if (retired !== exp_ret) begin errors++; $display("FAIL sw_ret_after got %0d want %0d", retired, exp_ret); end
      end
      if (i < 7) @(negedge clk);
    end
  endtask

  task automatic test_beq;
    state_t se[5] = '{FETCH, FETCH, DECODE, BEQ, FETCH};
    opcode = OP_BRANCH; zero = 1;
    for (int i = 0; i < 5; i++) begin
      mem_ready = i != 0; #1;
      checks++; if (state !== 4'(se[i])) begin errors++; $display("FAIL beq1_state[%0d] got %0d want %0d", i, state, se[i]); end
      if (i == 0) begin
        checks++; if ({mem_req, ir_write, pc_write} !== 3'b100) begin
          errors++; $display("FAIL beq1_fetchwait got %b want 100", {mem_req, ir_write, pc_write}); end
      end
      if (i == 1) begin
        checks++; if ({ir_write, pc_write} !== 2'b11) begin errors++; $display("FAIL beq1_fetchrdy got %b want 11", {ir_write, pc_write}); end
      end
      if (i == 3) begin
        checks++; if ({pc_write, alu_op, alu_src_a, alu_src_b} !== 7'b1011000) begin
          errors++; $display("FAIL beq1_exec got %b want 1011000", {pc_write, alu_op, alu_src_a, alu_src_b}); end
      end
      if (i < 4) @(negedge clk);
    end
    exp_ret++;
    checks++; if (retired !== exp_ret) begin errors++; $display("FAIL beq1_ret got %0d want %0d", retired, exp_ret); end
    zero = 0; mem_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (state !== 4'(se[i+1])) begin errors++; $display("FAIL beq0_state[%0d] got %0d want %0d", i, state, se[i+1]); end
      if (i == 2) begin
        checks++; if ({pc_write, alu_op} !== 3'b001) begin errors++; $display("FAIL beq0_exec got %b want 001", {pc_write, alu_op}); end
      end
      if (i < 3) @(negedge clk);
    end
    exp_ret++;
    checks++; if (retired !== exp_ret) begin errors++; $display("FAIL beq0_ret got %0d want %0d", retired, exp_ret); end
  endtask

  task automatic test_alu;
    state_t se[5];
    mem_ready = 1;
    for (int k = 0; k < 2; k++) begin
      opcode = k == 0 ? OP_RTYPE : OP_ITYPE;
      se = '{FETCH, DECODE, k == 0 ? EXECR : EXECI, ALUWB, FETCH};
      for (int i = 0; i < 5; i++) begin
        #1;
        checks++; if (state !== 4'(se[i])) begin errors++; $display("FAIL alu%0d_state[%0d] got %0d want %0d", k, i, state, se[i]); end
        if (i == 1) begin
          checks++; if ({alu_src_a, alu_src_b} !== 4'b0101) begin errors++; $display("FAIL alu%0d_decode got %b want 0101", k, {alu_src_a, alu_src_b}); end
        end
        if (i == 2) begin
          checks++; if ({alu_op, alu_src_a, alu_src_b, reg_write} !== {2'b10, 2'b10, k == 0 ? 2'b00 : 2'b01, 1'b0}) begin
            errors++; $display("FAIL alu%0d_exec got %b want %b", k, {alu_op, alu_src_a, alu_src_b, reg_write}, {2'b10, 2'b10, k == 0 ? 2'b00 : 2'b01, 1'b0}); end
        end
        if (i == 3) begin
          checks++; if ({reg_write, result_src} !== 3'b100) begin errors++; $display("FAIL alu%0d_wb got %b want 100", k, {reg_write, result_src}); end
        end
        if (i < 4) @(negedge clk);
      end
      exp_ret++;
      checks++; if (retired !== exp_ret) begin errors++; $display("FAIL alu%0d_ret got %0d want %0d", k, retired, exp_ret); end
    end
  endtask

  task automatic test_illegal;
    opcode = 7'h7F; mem_ready = 1;
    @(negedge clk); #1;
    checks++; if (state !== 4'(DECODE)) begin errors++; $display("FAIL ill_decode got %0d want %0d", state, DECODE); end
    @(negedge clk);
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({state, illegal, mem_req, ir_write, pc_write, reg_write} !== {4'(TRAP), 5'b10000}) begin
        errors++; $display("FAIL ill_trap[%0d] got %b want %b", i, {state, illegal, mem_req, ir_write, pc_write, reg_write}, {4'(TRAP), 5'b10000}); end
      @(negedge clk);
    end
    reset = 1; @(negedge clk); reset = 0; #1;
    exp_ret = 0;
    checks++; if ({state, illegal} !== {4'(FETCH), 1'b0}) begin errors++; $display("FAIL ill_exit got %b want %b", {state, illegal}, {4'(FETCH), 1'b0}); end
`else
    #1;
    checks++; if ({state, illegal} !== {4'(FETCH), 1'b0}) begin errors++; $display("FAIL ill_nop got %b want %b", {state, illegal}, {4'(FETCH), 1'b0}); end
`endif
    checks++; if (retired !== exp_ret) begin errors++; $display("FAIL ill_ret got %0d want %0d", retired, exp_ret); end
  endtask

  task automatic test_reset_mid;
    opcode = OP_STORE; mem_ready = 1;
    repeat (3) @(negedge clk);
    mem_ready = 0; #1;
    checks++; if ({state, mem_write} !== {4'(MEMWRITE), 1'b1}) begin errors++; $display("FAIL rstmid_pre got %b want %b", {state, mem_write}, {4'(MEMWRITE), 1'b1}); end
    reset = 1; #1;
    checks++; if ({mem_write, mem_req} !== 2'b00) begin errors++; $display("FAIL rstmid_drop got %b want 00", {mem_write, mem_req}); end
    @(negedge clk); #1;
    exp_ret = 0;
    checks++; if (state !== 4'(FETCH)) begin errors++; $display("FAIL rstmid_state got %0d want %0d", state, FETCH); end
    checks++; if (retired !== exp_ret) begin errors++; $display("FAIL rstmid_ret got %0d want 0", retired); end
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_wrap;
    opcode = OP_ITYPE; mem_ready = 1;
    for (int n = 1; n <= 16; n++) begin
      repeat (4) @(negedge clk);
      #1;
      checks++; if (retired4 !== 4'(n % 16)) begin errors++; $display("FAIL wrap4[%0d] got %0d want %0d", n, retired4, n % 16); end
    end
    checks++; if (retired !== 32'd16) begin errors++; $display("FAIL wrap32 got %0d want 16", retired); end
  endtask

  initial begin
    test_reset;
    test_lw;
    test_sw;
    test_beq;
    test_alu;
    test_illegal;
    test_reset_mid;
    test_wrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main sequencing FSM for the multi-cycle RV32I core: walks each instruction through fetch, decode, execute, memory and writeback, and drives the datapath mux selects, write strobes and the 2-bit ALU operation class consumed by the ALU-control decoder. Sits between the instruction register (opcode source), the ALU zero flag, and a shared instruction/data memory port with a ready handshake. It also keeps a retired-instruction counter.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  7  IR[6:0], stable from DECODE until next FETCH
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory access request, held until mem_ready
- adr_src  out  1  0=PC, 1=ALUOut as memory address
- mem_write  out  1  request is a store
- ir_write  out  1  load IR from memory read data
- pc_write  out  1  update PC
- reg_write  out  1  register file write enable
- alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1
- alu_src_b  out  2  00=rs2, 01=imm, 10=const 4
- alu_op  out  2  00=add, 01=sub (branch), 10=decode funct fields
- result_src  out  2  00=ALUOut, 01=mem data, 10=ALU result
- state  out  4  current state, debug
- retired  out  CNT_W  retired-instruction count, wraps
- illegal  out  1  unsupported opcode trapped

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, TRAP.
- Selects/alu_op not listed for a state are 00.
- FETCH: mem_req=1, adr_src=0, alu_src_b=10, result_src=10; on mem_ready: ir_write=1, pc_write=1, go DECODE; else hold.
- DECODE: alu_src_a=01, alu_src_b=01 (branch target into ALUOut). Next: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; other -> illegal handling.
- MEMADR: alu_src_a=10, alu_src_b=01; load -> MEMREAD, store -> MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1; on mem_ready -> MEMWB.
- MEMWB: result_src=01, reg_write=1 -> FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1; on mem_ready -> FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10 -> ALUWB. EXECI: same with alu_src_b=01.
- ALUWB: result_src=00, reg_write=1 -> FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00; pc_write=zero -> FETCH.
- retired increments by 1 on leaving MEMWB, ALUWB, BEQ, or MEMWRITE with mem_ready; wraps 2^CNT_W-1 -> 0. Never increments on illegal.

## Timing
- Reset: next edge state=FETCH, retired=0, illegal=0. While reset is high, mem_req, mem_write, ir_write, pc_write and reg_write are forced 0 combinationally. Reset mid-access (e.g. MEMWRITE) drops mem_write the same cycle.
- Zero-wait memory: beq 3 cycles, R/I-type 4, sw 4, lw 5. Each mem_ready-low cycle in FETCH/MEMREAD/MEMWRITE adds one cycle.
- mem_req, adr_src, mem_write stable while waiting. ir_write/pc_write pulse only in the mem_ready cycle.
- mem_ready outside the request states is ignored.
- opcode is sampled only in DECODE and MEMADR.

## Configuration
- ILLEGAL_TRAP_EN defined: unsupported opcode in DECODE -> TRAP. TRAP sets illegal=1, all strobes 0, and holds until reset.
- Undefined: unsupported opcode goes DECODE -> FETCH as a NOP, not counted in retired; TRAP unreachable; illegal tied 0.

## Structure
- Shared package ctrl_pkg: state_t enum (4-bit encoding), opcode constants, alu_op encodings, alu_src_a/alu_src_b/result_src select encodings. ALU-control and datapath import the same encodings.
- One sub-module: retire_counter (CNT_W, sync reset, increment enable, wrap).

## Test plan
- lw, mem_ready always 1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH in 5 cycles; reg_write=1 with result_src=01 in cycle 5; retired 0->1.
- sw with mem_ready low 3 cycles in MEMWRITE -> mem_req/mem_write/adr_src=1 held 4 cycles; no reg_write; retired increments only on the ready cycle.
- beq: zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0. Both take 3 cycles; alu_op=01.
- opcode 7'h7F: with ILLEGAL_TRAP_EN, TRAP reached, illegal=1, stuck until reset. Without the macro, back to FETCH next cycle with retired unchanged.
- reset asserted in MEMWRITE while mem_ready=0 -> mem_write=0 same cycle; FETCH next edge; retired=0.
- CNT_W=4: retire 16 addi -> retired wraps 15->0.
